// File: rtl/iob_spi_flash_line_fill_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : iob_spi_flash_line_fill_pkg
//  Purpose  : Shared types and sizing helpers for the SPI flash line-fill
//             prefetch buffer.
//  Revision : 1.0  initial release
// ============================================================================
package iob_spi_flash_line_fill_pkg;

   localparam int DEF_DATA_W     = 32;
   localparam int DEF_ADDR_W     = 24;
   localparam int DEF_LINE_WORDS = 4;

   // Word-index width inside a line; a one-word line still needs one bit.
   function automatic int widx_width(input int line_words);
      return (line_words < 2) ? 1 : $clog2(line_words);
   endfunction

   localparam int WIDX_W = widx_width(DEF_LINE_WORDS);
   localparam int TAG_W  = DEF_ADDR_W - 2 - WIDX_W;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_GAP  = 2'd2,
      ST_RESP = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/iob_spi_flash_line_fill_if.sv
`default_nettype none
// ============================================================================
//  Module   : iob_spi_flash_line_fill_if
//  Purpose  : CPU native-bus side and flash-controller cache-port side of the
//             line-fill buffer. The slave modport is the buffer's view.
//  Revision : 1.0  initial release
// ============================================================================
interface iob_spi_flash_line_fill_if
   import iob_spi_flash_line_fill_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) ();

   // CPU side
   logic                  iob_valid;
   logic [ADDR_W-1:0]     iob_addr;
   logic [DATA_W/8-1:0]   iob_wstrb;
   logic [DATA_W-1:0]     iob_rdata;
   logic                  iob_rvalid;
   logic                  iob_ready;

   // Flash controller side
   logic                  fl_valid;
   logic [ADDR_W-1:0]     fl_addr;
   logic [DATA_W/8-1:0]   fl_wstrb;
   logic [DATA_W-1:0]     fl_rdata;
   logic                  fl_ready;

   modport slave (
      input  iob_valid, iob_addr, iob_wstrb,
      output iob_rdata, iob_rvalid, iob_ready,
      output fl_valid, fl_addr, fl_wstrb,
      input  fl_rdata, fl_ready
   );

   modport master (
      output iob_valid, iob_addr, iob_wstrb,
      input  iob_rdata, iob_rvalid, iob_ready,
      input  fl_valid, fl_addr, fl_wstrb,
      output fl_rdata, fl_ready
   );

endinterface
`default_nettype wire

// File: rtl/iob_spi_line_buf.sv
`default_nettype none
// ============================================================================
//  Module   : iob_spi_line_buf
//  Purpose  : One cache line of DATA_W words; single write port, asynchronous
//             read port. Data is not reset: validity is tracked by the owner.
//  Revision : 1.0  initial release
// ============================================================================
module iob_spi_line_buf #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4,
   parameter int AW     = 2
) (
   input  wire logic              clk_i,
   input  wire logic              i_we,
   input  wire logic [AW-1:0]     i_waddr,
   input  wire logic [DATA_W-1:0] i_wdata,
   input  wire logic [AW-1:0]     i_raddr,
   output logic      [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   // Capture one returned flash word into its slot of the line.
   always_ff @(posedge clk_i) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/iob_spi_flash_line_fill.sv
`default_nettype none
// ============================================================================
//  Module   : iob_spi_flash_line_fill
//  Purpose  : Read-only single-line prefetch buffer between the CPU native bus
//             and the SPI flash controller cache port. Hits answer from the
//             line register; misses fetch the whole aligned line word 0 up.
//  Revision : 1.0  initial release
// ============================================================================
module iob_spi_flash_line_fill
   import iob_spi_flash_line_fill_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int LINE_WORDS = DEF_LINE_WORDS
) (
   input  wire logic                clk_i,
   input  wire logic                arst_n_i,
   input  wire logic                inv_i,
   output logic                     busy_o,
   iob_spi_flash_line_fill_if.slave bus
);

   localparam int c_WIDX_W = widx_width(LINE_WORDS);
   localparam int c_TAG_W  = ADDR_W - 2 - c_WIDX_W;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  r_line_vld;
   logic                  r_inv_pend;
   logic                  r_rvalid;
   logic [DATA_W-1:0]     r_rdata;
   logic [c_TAG_W-1:0]    r_tag;
   logic [c_WIDX_W-1:0]   r_widx;
   logic [c_WIDX_W-1:0]   r_cnt;

   logic [c_TAG_W-1:0]    w_tag_in;
   logic [c_WIDX_W-1:0]   w_widx_in;
   logic                  w_rd;
   logic                  w_hit;
   logic                  w_miss;
   logic                  w_last;
   logic                  w_buf_we;
   logic [c_WIDX_W-1:0]   w_buf_raddr;
   logic [DATA_W-1:0]     w_buf_rdata;
   logic                  w_unused_addr;

   assign w_tag_in  = bus.iob_addr[ADDR_W-1:2+c_WIDX_W];
   assign w_widx_in = bus.iob_addr[2+c_WIDX_W-1:2];
   // Byte-lane bits are irrelevant for word reads.
   assign w_unused_addr = &{1'b0, bus.iob_addr[1:0]};

   // A simultaneous invalidate forces the accepted read to miss.
   assign w_rd     = bus.iob_valid & (r_state == ST_IDLE) & ~(|bus.iob_wstrb);
   assign w_hit    = r_line_vld & ~inv_i & (w_tag_in == r_tag);
   assign w_miss   = w_rd & ~w_hit;
   assign w_last   = (r_cnt == c_WIDX_W'(LINE_WORDS - 1));
   assign w_buf_we = (r_state == ST_REQ) & bus.fl_ready;
   // IDLE serves hits at the incoming index; a fill answers at the latched one.
   assign w_buf_raddr = (r_state == ST_IDLE) ? w_widx_in : r_widx;

   iob_spi_line_buf #(
      .DATA_W (DATA_W),
      .DEPTH  (LINE_WORDS),
      .AW     (c_WIDX_W)
   ) u_line_buf (
      .clk_i   (clk_i),
      .i_we    (w_buf_we),
      .i_waddr (r_cnt),
      .i_wdata (bus.fl_rdata),
      .i_raddr (w_buf_raddr),
      .o_rdata (w_buf_rdata)
   );

   // State register.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic: one flash word per REQ, one idle GAP after each word.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_miss)        w_state_nxt = ST_REQ;
         ST_REQ:  if (bus.fl_ready)  w_state_nxt = ST_GAP;
         ST_GAP:  w_state_nxt = w_last ? ST_RESP : ST_REQ;
         ST_RESP: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Tag/valid/invalidate tracking, fill counter and registered CPU response.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         r_line_vld <= 1'b0;
         r_inv_pend <= 1'b0;
         r_rvalid   <= 1'b0;
         r_rdata    <= '0;
         r_tag      <= '0;
         r_widx     <= '0;
         r_cnt      <= '0;
      end else begin
         r_rvalid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_rd && w_hit) begin
                  r_rvalid <= 1'b1;
                  r_rdata  <= w_buf_rdata;
               end else if (w_miss) begin
                  r_tag      <= w_tag_in;
                  r_widx     <= w_widx_in;
                  r_cnt      <= '0;
                  r_line_vld <= 1'b0;
                  r_inv_pend <= 1'b0;
               end
               if (inv_i) begin
                  r_line_vld <= 1'b0;
               end
            end
            ST_REQ: begin
               if (inv_i) begin
                  r_inv_pend <= 1'b1;
               end
            end
            ST_GAP: begin
               if (inv_i) begin
                  r_inv_pend <= 1'b1;
               end
               if (w_last) begin
                  r_rvalid <= 1'b1;
                  r_rdata  <= w_buf_rdata;
               end else begin
                  r_cnt <= r_cnt + c_WIDX_W'(1);
               end
            end
            ST_RESP: begin
               r_line_vld <= ~(r_inv_pend | inv_i);
               r_inv_pend <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.iob_ready  = (r_state == ST_IDLE);
   assign bus.iob_rvalid = r_rvalid;
   assign bus.iob_rdata  = r_rdata;
   assign bus.fl_valid   = (r_state == ST_REQ);
   assign bus.fl_addr    = {r_tag, r_cnt, 2'b00};
   assign bus.fl_wstrb   = '0;
   assign busy_o         = (r_state != ST_IDLE);

endmodule
`default_nettype wire
